// File: rtl/pipemdu_if.sv
// Issue/result bundle between the ID stage and the iterative multiply/divide unit.
interface pipemdu_if #(
  parameter int DATA_W = 32
);
  logic              dstart;
  logic [1:0]        dmdop;
  logic [DATA_W-1:0] da;
  logic [DATA_W-1:0] db;
  logic              dmfhilo;
  logic              busy;
  logic              mdstall;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output dstart, dmdop, da, db, dmfhilo,
    input  busy, mdstall, done, hi, lo
  );

  modport slave (
    input  dstart, dmdop, da, db, dmfhilo,
    output busy, mdstall, done, hi, lo
  );
endinterface

// File: rtl/pipemdu.sv
// Iterative MIPS-style HI/LO unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on magnitudes, sign fix-up at the end.
module pipemdu #(
  parameter int DATA_W = 32
) (
  input  logic      clock,
  input  logic      resetn,
  pipemdu_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic                  r_sa;
  logic                  r_sb;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_done;

  logic                  w_busy;
  logic                  w_neg_a;
  logic                  w_neg_b;
  logic [DATA_W-1:0]     w_mag_a;
  logic [DATA_W-1:0]     w_mag_b;
  logic [DATA_W:0]       w_mul_sum;
  logic [2*DATA_W-1:0]   w_mul_next;
  logic [DATA_W:0]       w_div_shift;
  logic                  w_div_ge;
  logic [DATA_W-1:0]     w_div_diff;
  logic [2*DATA_W-1:0]   w_div_next;
  logic [2*DATA_W-1:0]   w_mul_res;
  logic                  w_div0;
  logic [DATA_W-1:0]     w_res_hi;
  logic [DATA_W-1:0]     w_res_lo;

  function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v,
                                              input logic neg);
    return neg ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] f_cneg_w(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] f_cneg_2w(input logic [2*DATA_W-1:0] v,
                                                    input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Operand capture: sign flags are only ever set for the signed ops
  assign w_neg_a = ~bus.dmdop[0] & bus.da[DATA_W-1];
  assign w_neg_b = ~bus.dmdop[0] & bus.db[DATA_W-1];
  assign w_mag_a = f_abs(bus.da, w_neg_a);
  assign w_mag_b = f_abs(bus.db, w_neg_b);

  // Multiply step: acc = {partial, multiplier}, add multiplicand on LSB then shift right
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_acc[0] ? r_a : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; difference fits DATA_W when it is kept
  assign w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_div_ge    = w_div_shift >= {1'b0, r_b};
  assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_b;
  assign w_div_next  = w_div_ge ? {w_div_diff, r_acc[DATA_W-2:0], 1'b1}
                                : {w_div_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

  // Sign fix-up; a zero divisor leaves the dividend as remainder, restored to da by its sign
  assign w_mul_res = f_cneg_2w(r_acc, ~r_op[0] & (r_sa ^ r_sb));
  assign w_div0    = (r_b == '0);

  always_comb begin
    w_res_hi = w_mul_res[2*DATA_W-1:DATA_W];
    w_res_lo = w_mul_res[DATA_W-1:0];
    if (r_op[1]) begin
      w_res_hi = f_cneg_w(r_acc[2*DATA_W-1:DATA_W], r_sa);
      w_res_lo = w_div0 ? '1 : f_cneg_w(r_acc[DATA_W-1:0], r_sa ^ r_sb);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.dstart) begin
            r_op    <= bus.dmdop;
            r_sa    <= w_neg_a;
            r_sb    <= w_neg_b;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_acc   <= {{DATA_W{1'b0}}, (bus.dmdop[1] ? w_mag_a : w_mag_b)};
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy      = (r_state != S_IDLE);
  assign bus.busy    = w_busy;
  assign bus.mdstall = w_busy & (bus.dstart | bus.dmfhilo);
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
endmodule

// File: tb/tb_pipemdu.sv
// Self-checking bench for pipemdu: directed table, corner sequences, and
// random ops against an arithmetic reference model.
module tb_pipemdu;
  logic clock;
  logic resetn;
  int   n_vec;
  int   n_mis;

  pipemdu_if #(.DATA_W(32)) u_if ();

  pipemdu #(.DATA_W(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          mfh;
    int          inj;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issue an op now (between edges) and follow it to completion
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mfh, input int inj,
                        output logic [31:0] rhi, output logic [31:0] rlo);
    logic [31:0] hi0, lo0;
    int cyc;
    hi0 = u_if.hi;
    lo0 = u_if.lo;
    u_if.dstart  = 1'b1;
    u_if.dmdop   = op;
    u_if.da      = a;
    u_if.db      = b;
    u_if.dmfhilo = mfh;
    @(posedge clock); #1;
    u_if.dstart = 1'b0;
    u_if.da     = $urandom;
    u_if.db     = $urandom;
    chk("start_busy", {63'd0, u_if.busy}, 64'd1);
    chk("start_done_low", {63'd0, u_if.done}, 64'd0);
    cyc = 0;
    while (u_if.busy && cyc < 100) begin
      cyc++;
      if (mfh) chk("stall_busy", {63'd0, u_if.mdstall}, 64'd1);
      if (cyc == 16) chk("hilo_hold", {u_if.hi, u_if.lo}, {hi0, lo0});
      if (cyc == inj) begin
        u_if.dstart = 1'b1;
        u_if.dmdop  = 2'($urandom);
      end
      @(posedge clock); #1;
      u_if.dstart = 1'b0;
    end
    if (cyc >= 100) chk("timeout", 64'(cyc), 64'd33);
    else chk("latency", 64'(cyc), 64'd33);
    chk("done_pulse", {63'd0, u_if.done}, 64'd1);
    if (mfh) chk("stall_done_cycle", {63'd0, u_if.mdstall}, 64'd0);
    u_if.dmfhilo = 1'b0;
    rhi = u_if.hi;
    rlo = u_if.lo;
  endtask

  initial begin
    logic [31:0] rhi, rlo, a, b;
    logic [1:0]  op;
    logic [63:0] exp;
    n_vec = 0;
    n_mis = 0;

    tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0};
    tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0};
    tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0};
    tbl[3] = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b0, 0};
    tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0};
    tbl[5] = '{2'b10, 32'h80000005, 32'h00000000, 32'h80000005, 32'hFFFFFFFF, 1'b0, 0};
    tbl[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0};
    tbl[7] = '{2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1, 5};
    tbl[8] = '{2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0, 0};

    resetn       = 1'b0;
    u_if.dstart  = 1'b0;
    u_if.dmdop   = 2'b00;
    u_if.da      = '0;
    u_if.db      = '0;
    u_if.dmfhilo = 1'b0;
    #1;
    chk("rst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("rst_mdstall", {63'd0, u_if.mdstall}, 64'd0);
    chk("rst_done", {63'd0, u_if.done}, 64'd0);
    chk("rst_hilo", {u_if.hi, u_if.lo}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Directed table; each op is issued in the done cycle of the previous one
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].mfh, tbl[i].inj, rhi, rlo);
      chk($sformatf("tbl%0d_hilo", i), {rhi, rlo}, {tbl[i].hi, tbl[i].lo});
    end

    // Reset in the middle of a divide must abort it and clear everything at once
    u_if.dstart = 1'b1;
    u_if.dmdop  = 2'b11;
    u_if.da     = 32'd1000;
    u_if.db     = 32'd3;
    @(posedge clock); #1;
    u_if.dstart = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("midrst_done", {63'd0, u_if.done}, 64'd0);
    chk("midrst_hilo", {u_if.hi, u_if.lo}, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", {63'd0, u_if.busy}, 64'd0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 0, rhi, rlo);
    chk("divu_100_7", {rhi, rlo}, {32'd2, 32'd14});

    // Random ops, with zero and extreme operands mixed in
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, 1'($urandom), 0, rhi, rlo);
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), {rhi, rlo}, exp);
    end

    @(posedge clock); #1;
    chk("done_falls", {63'd0, u_if.done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/pipemdu.md
PIPEMDU -- requirements
Module: pipemdu

Interface
REQ-001 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 Port dstart, input, 1 bit: the ID stage issues a multiply/divide op this cycle, already qualified by ID stall logic.
REQ-004 Port dmdop, input, 2 bits: operation select; 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 Port da, input, 32 bits: rs operand (forwarded); multiplicand or dividend.
REQ-006 Port db, input, 32 bits: rt operand (forwarded); multiplier or divisor.
REQ-007 Port dmfhilo, input, 1 bit: the ID-stage instruction reads HI or LO (mfhi/mflo).
REQ-008 Port busy, output, 1 bit: an operation is in progress.
REQ-009 Port mdstall, output, 1 bit: stall request; the ID stage ANDs its inverse into wpcir.
REQ-010 Port done, output, 1 bit: one-cycle pulse when HI/LO have just been updated.
REQ-011 Port hi, output, 32 bits: HI register.
REQ-012 Port lo, output, 32 bits: LO register.

Function
REQ-013 States SHALL be IDLE, RUN and FIX; busy SHALL equal (state != IDLE).
REQ-014 In IDLE with dstart=1, the block SHALL latch dmdop, the sign flags, and the magnitudes of da/db (magnitudes for signed ops, raw values for unsigned ops), clear the 5-bit iteration counter, and enter RUN.
REQ-015 In RUN, the block SHALL perform one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 In RUN, the counter SHALL increment each cycle; when count==31, the next state SHALL be FIX, for exactly 32 RUN cycles.
REQ-017 In FIX, the block SHALL apply sign correction, write hi/lo on the exit edge, and return to IDLE.
REQ-018 done SHALL be a registered output, high for the single cycle after the FIX exit edge.
REQ-019 Latency: dstart sampled at edge k SHALL give busy=1 for 33 cycles and hi/lo valid after edge k+33.
REQ-020 Multiply: {hi,lo} SHALL hold the 64-bit product; for mult, the product is negated when the operand signs differ.
REQ-021 Divide: lo SHALL be the quotient and hi the remainder; the quotient sign is the XOR of the operand signs, and the remainder sign follows the dividend.
REQ-022 Divide by zero (db==0, either divide op) SHALL give lo=0xFFFFFFFF and hi=original da, with the normal 33-cycle latency.
REQ-023 div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 without any exception.
REQ-024 mdstall SHALL equal busy & (dstart | dmfhilo), combinationally.
REQ-025 dstart while busy SHALL be ignored; the operands are not relatched and the running operation is unaffected.
REQ-026 dstart in the done cycle (state IDLE) SHALL be accepted normally as back-to-back issue.
REQ-027 hi/lo SHALL hold their values at all times except the FIX exit edge; they are readable during RUN, but reads are stalled by REQ-024.
REQ-028 dmdop values are exhaustive; no illegal encoding exists.

Reset
REQ-029 resetn=0 SHALL immediately force: state IDLE, counter 0, busy=0, mdstall=0, done=0, hi=0, lo=0, and internal operand/accumulator registers 0.
REQ-030 Reset asserted mid-operation SHALL abort it; no partial result reaches hi/lo.
REQ-031 After resetn deasserts, the first rising edge with dstart=1 SHALL start a new operation.

Verification
REQ-032 multu da=0xFFFFFFFF db=0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle.
REQ-033 mult da=0xFFFFFFFD (-3) db=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 div da=0xFFFFFFF9 (-7) db=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu da=7 db=0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 mult issued, then dmfhilo=1 held -> mdstall=1 every busy cycle, 0 in the done cycle; a second dstart at RUN cycle 5 is ignored and the result matches the first op.
REQ-036 resetn pulsed low at RUN cycle 10 -> busy, hi, lo and done read 0 before the next edge; a fresh divu 100/7 afterwards -> lo=14, hi=2.
REQ-037 Back-to-back: dstart (multu 3x4) in the done cycle of the prior op -> accepted, result hi=0, lo=12 after 33 cycles.
